hazard_ctrl: RTL and testbench

- Pipeline hazard and flush controller for the 5-stage core.
- Produces the stall, stall_bot, override_FD, override_DX and mispredict event signals. The performance runner counts these as noops and mispredicts.
- Contains the multdiv stall sequencer and a 2-bit branch predictor.
- Sits beside the FD/DX latches in the skeleton. Drives their enable and flush inputs.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_bpred_table.sv | 30 +++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 tb/tb_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/flush controller.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 6;

    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

    // One saturating step of a 2-bit counter toward the resolved outcome.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        if (up) return (c == STRONG_T) ? c : c + 2'd1;
        return (c == STRONG_NT) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_bpred_table.sv
// 2-bit saturating branch predictor table: combinational lookup, posedge update.
module bpred_table
    import hazard_pkg::*;
#(
    parameter int BP_ENTRIES = 16,
    parameter int BP_IDX_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [BP_IDX_W-1:0] lookup_idx,
    output logic                pred_taken,
    input  logic                upd_en,
    input  logic [BP_IDX_W-1:0] upd_idx,
    input  logic                upd_taken
);

    logic [1:0] ctr [BP_ENTRIES];

    // Lookup reads the pre-update value when it aliases the update index.
    assign pred_taken = ctr[lookup_idx][1];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < BP_ENTRIES; i++) ctr[i] <= WEAK_NT;
        end else if (upd_en) begin
            ctr[upd_idx] <= sat_step(ctr[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller with multdiv sequencer; the predictor table is
// built only when HAZARD_BPRED_EN is defined (otherwise static not-taken).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int BP_ENTRIES = 16,
    parameter int BP_IDX_W   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      f_pc,
    output logic             pred_taken,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             fd_uses_rs,
    input  logic             fd_uses_rt,
    input  logic             fd_is_jump,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             dx_is_load,
    input  logic             dx_is_multdiv,
    input  logic             dx_is_branch,
    input  logic             dx_is_jr,
    input  logic             dx_taken,
    input  logic             dx_pred_taken,
    input  logic [31:0]      dx_pc,
    output logic             stall,
    output logic             stall_bot,
    output logic             override_FD,
    output logic             override_DX,
    output logic             mispredict,
    output logic             md_busy
);

    md_state_t        state;
    logic [CNT_W-1:0] md_cnt;
    logic             md_done;
    logic             md_req, stall_raw, load_use, mp_raw, ovr_dx_raw, bp_pred;
    logic             unused_bits;

    assign md_req    = dx_is_multdiv & ~md_done;
    assign stall_raw = (state == BUSY) | ((state == IDLE) & md_req);
    assign load_use  = dx_is_load & (dx_rd != '0) &
                       ((fd_uses_rs & (fd_rs == dx_rd)) | (fd_uses_rt & (fd_rt == dx_rd)));

`ifdef HAZARD_BPRED_EN
    bpred_table #(.BP_ENTRIES(BP_ENTRIES), .BP_IDX_W(BP_IDX_W)) u_bpred (
        .clock      (clock),
        .reset      (reset),
        .lookup_idx (f_pc[BP_IDX_W+1:2]),
        .pred_taken (bp_pred),
        .upd_en     (reset & dx_is_branch & ~stall),
        .upd_idx    (dx_pc[BP_IDX_W+1:2]),
        .upd_taken  (dx_taken)
    );
    assign mp_raw = dx_is_branch & (dx_taken != dx_pred_taken);
`else
    assign bp_pred = 1'b0;
    assign mp_raw  = dx_is_branch & dx_taken;
`endif

    // PC bits outside the index field (and the whole PCs in the static build) are unused.
    assign unused_bits = ^{f_pc, dx_pc, dx_pred_taken};

    assign pred_taken  = bp_pred;
    assign ovr_dx_raw  = mp_raw | dx_is_jr;

    assign mispredict  = reset & mp_raw;
    assign override_DX = reset & ovr_dx_raw;
    assign stall       = reset & ~ovr_dx_raw & stall_raw;
    assign stall_bot   = reset & ~ovr_dx_raw & ~stall_raw & load_use;
    assign override_FD = reset & ~ovr_dx_raw & ~stall_raw & ~load_use & fd_is_jump;
    assign md_busy     = reset & (state == BUSY);

    // The trigger cycle is the first stall cycle, so BUSY lasts MD_LATENCY-1 cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            md_cnt  <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (md_req & ~ovr_dx_raw) begin
                        if (MD_LATENCY > 1) begin
                            state  <= BUSY;
                            md_cnt <= CNT_W'(MD_LATENCY - 1);
                        end else begin
                            md_done <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    md_cnt <= md_cnt - 1'b1;
                    if (md_cnt == CNT_W'(1)) begin
                        state   <= IDLE;
                        md_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural model (tracks HAZARD_BPRED_EN).
module tb_hazard_ctrl;

    localparam int MD_LATENCY = 32;
    localparam int BP_ENTRIES = 16;
`ifdef HAZARD_BPRED_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] f_pc;
        logic [31:0] dx_pc;
        logic [4:0]  fd_rs, fd_rt, dx_rd;
        logic        fd_uses_rs, fd_uses_rt, fd_is_jump;
        logic        dx_is_load, dx_is_multdiv, dx_is_branch, dx_is_jr;
        logic        dx_taken, dx_pred_taken;
    } in_t;

    // exp = {stall, stall_bot, override_FD, override_DX, mispredict}
    typedef struct {
        in_t        i;
        logic [4:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    in_t  cur   = '0;
    logic pred_taken, stall, stall_bot, override_FD, override_DX, mispredict, md_busy;

    int checks = 0;
    int errors = 0;

    // reference state: remaining BUSY cycles, just-finished flag, counter table
    int md_rem = 0;
    bit md_sup = 1'b0;
    int pht [BP_ENTRIES];
    bit e_st, e_sb, e_fd, e_odx, e_mp, e_busy, e_pred, e_md, e_odx_raw;

    always #5 clock = ~clock;

    hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .BP_ENTRIES(BP_ENTRIES), .BP_IDX_W(4)) dut (
        .clock         (clock),
        .reset         (rst_n),
        .f_pc          (cur.f_pc),
        .pred_taken    (pred_taken),
        .fd_rs         (cur.fd_rs),
        .fd_rt         (cur.fd_rt),
        .fd_uses_rs    (cur.fd_uses_rs),
        .fd_uses_rt    (cur.fd_uses_rt),
        .fd_is_jump    (cur.fd_is_jump),
        .dx_rd         (cur.dx_rd),
        .dx_is_load    (cur.dx_is_load),
        .dx_is_multdiv (cur.dx_is_multdiv),
        .dx_is_branch  (cur.dx_is_branch),
        .dx_is_jr      (cur.dx_is_jr),
        .dx_taken      (cur.dx_taken),
        .dx_pred_taken (cur.dx_pred_taken),
        .dx_pc         (cur.dx_pc),
        .stall         (stall),
        .stall_bot     (stall_bot),
        .override_FD   (override_FD),
        .override_DX   (override_DX),
        .mispredict    (mispredict),
        .md_busy       (md_busy)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0b want=%0b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int bidx(input logic [31:0] pc);
        return int'((pc >> 2) % BP_ENTRIES);
    endfunction

    // Evaluate the rules on the current inputs and compare every output.
    task automatic settle();
        bit mp, lu;
        #2;
        mp = cur.dx_is_branch && (BP ? (cur.dx_taken != cur.dx_pred_taken) : cur.dx_taken);
        e_odx_raw = mp || cur.dx_is_jr;
        e_md   = (md_rem > 0) || (cur.dx_is_multdiv && !md_sup);
        lu     = cur.dx_is_load && cur.dx_rd != 0 &&
                 ((cur.fd_uses_rs && cur.fd_rs == cur.dx_rd) || (cur.fd_uses_rt && cur.fd_rt == cur.dx_rd));
        e_mp   = rst_n && mp;
        e_odx  = rst_n && e_odx_raw;
        e_st   = rst_n && !e_odx_raw && e_md;
        e_sb   = rst_n && !e_odx_raw && !e_md && lu;
        e_fd   = rst_n && !e_odx_raw && !e_md && !lu && cur.fd_is_jump;
        e_busy = rst_n && md_rem > 0;
        e_pred = BP && pht[bidx(cur.f_pc)] >= 2;
        chk("stall", stall, e_st);
        chk("stall_bot", stall_bot, e_sb);
        chk("override_FD", override_FD, e_fd);
        chk("override_DX", override_DX, e_odx);
        chk("mispredict", mispredict, e_mp);
        chk("md_busy", md_busy, e_busy);
        chk("pred_taken", pred_taken, e_pred);
    endtask

    task automatic advance();
        int k;
        @(posedge clock);
        if (!rst_n) begin
            md_rem = 0;
            md_sup = 1'b0;
            for (int i = 0; i < BP_ENTRIES; i++) pht[i] = 1;
        end else begin
            if (cur.dx_is_branch && !e_st) begin
                k = bidx(cur.dx_pc);
                pht[k] = cur.dx_taken ? ((pht[k] < 3) ? pht[k] + 1 : 3)
                                      : ((pht[k] > 0) ? pht[k] - 1 : 0);
            end
            if (md_rem > 0) begin
                md_rem--;
                md_sup = (md_rem == 0);
            end else if (e_md && !e_odx_raw) begin
                md_rem = MD_LATENCY - 1;
                md_sup = (MD_LATENCY == 1);
            end else begin
                md_sup = 1'b0;
            end
        end
        @(negedge clock);
    endtask

    vec_t vec [10];

    initial begin
        int first, last, nst, nbusy;
        for (int i = 0; i < BP_ENTRIES; i++) pht[i] = 1;

        // table: combinational hazards from an idle sequencer
        for (int k = 0; k < 10; k++) vec[k].i = '0;
        vec[0].i.dx_is_load = 1; vec[0].i.dx_rd = 5; vec[0].i.fd_uses_rs = 1; vec[0].i.fd_rs = 5;
        vec[0].exp = 5'b01000;
        vec[1].i.dx_is_load = 1; vec[1].i.dx_rd = 0; vec[1].i.fd_uses_rs = 1; vec[1].i.fd_rs = 0;
        vec[1].exp = 5'b00000;
        vec[2].i.dx_is_load = 1; vec[2].i.dx_rd = 5; vec[2].i.fd_uses_rs = 1; vec[2].i.fd_rs = 3;
        vec[2].i.fd_uses_rt = 1; vec[2].i.fd_rt = 5;
        vec[2].exp = 5'b01000;
        vec[3].i.dx_is_load = 1; vec[3].i.dx_rd = 5; vec[3].i.fd_rs = 5;
        vec[3].exp = 5'b00000;
        vec[4].i.fd_is_jump = 1; vec[4].i.dx_is_jr = 1;
        vec[4].exp = 5'b00010;
        vec[5].i.fd_is_jump = 1;
        vec[5].exp = 5'b00100;
        vec[6] = vec[0]; vec[6].i.fd_is_jump = 1;
        vec[6].exp = 5'b01000;
        vec[7] = vec[0]; vec[7].i.dx_is_branch = 1; vec[7].i.dx_taken = 1; vec[7].i.dx_pc = 32'h84;
        vec[7].exp = 5'b00011;
        vec[8].i.dx_is_branch = 1; vec[8].i.dx_pred_taken = 1; vec[8].i.dx_pc = 32'h84;
        vec[8].exp = {3'b000, BP, BP};
        vec[9] = vec[8]; vec[9].i.dx_taken = 1;
        vec[9].exp = {3'b000, !BP, !BP};

        // reset with active inputs: everything held low
        cur = '0; cur.dx_is_multdiv = 1; cur.dx_is_jr = 1; cur.fd_is_jump = 1;
        @(negedge clock);
        advance();
        settle();
        chk("rst_stall", stall, 1'b0);
        chk("rst_ovr_dx", override_DX, 1'b0);
        advance();
        cur = '0;
        rst_n = 1'b1;
        settle(); advance();

        for (int k = 0; k < 10; k++) begin
            cur = vec[k].i;
            settle();
            chk("vec_stall", stall, vec[k].exp[4]);
            chk("vec_stall_bot", stall_bot, vec[k].exp[3]);
            chk("vec_ovr_fd", override_FD, vec[k].exp[2]);
            chk("vec_ovr_dx", override_DX, vec[k].exp[1]);
            chk("vec_mispredict", mispredict, vec[k].exp[0]);
            advance();
        end
        cur = '0; settle(); advance();

        // multdiv: single-cycle request, then request held past completion
        for (int pass = 0; pass < 2; pass++) begin
            first = -1; last = -1; nst = 0; nbusy = 0;
            for (int i = 0; i < 40; i++) begin
                cur = '0;
                cur.dx_is_multdiv = (pass == 0) ? (i == 0) : (i <= MD_LATENCY);
                settle();
                if (stall) begin
                    nst++; last = i;
                    if (first < 0) first = i;
                end
                if (md_busy) nbusy++;
                advance();
            end
            chki("md_stall_cycles", nst, MD_LATENCY);
            chki("md_busy_cycles", nbusy, MD_LATENCY - 1);
            chki("md_first", first, 0);
            chki("md_last", last, MD_LATENCY - 1);
        end

        // branch at 0x40: mispredict, train, saturate, same-cycle lookup/update
        cur = '0; cur.dx_is_branch = 1; cur.dx_taken = 1; cur.dx_pc = 32'h40;
        settle();
        chk("br_mispredict", mispredict, 1'b1);
        chk("br_ovr_dx", override_DX, 1'b1);
        advance();
        cur = '0; cur.f_pc = 32'h40;
        settle();
        chk("br_pred_after1", pred_taken, BP);
        advance();
        for (int i = 0; i < 3; i++) begin
            cur = '0; cur.dx_is_branch = 1; cur.dx_taken = 1; cur.dx_pred_taken = 1; cur.dx_pc = 32'h40;
            settle(); advance();
        end
        cur = '0; cur.dx_is_branch = 1; cur.dx_pred_taken = 1; cur.dx_pc = 32'h40; cur.f_pc = 32'h40;
        settle();
        chk("br_pred_sat", pred_taken, BP);
        advance();
        cur.dx_pred_taken = 0;
        settle();
        chk("br_pred_old_val", pred_taken, BP);
        advance();
        cur = '0; cur.f_pc = 32'h40;
        settle();
        chk("br_pred_weak_nt", pred_taken, 1'b0);
        advance();

        // reset 5 cycles into a multdiv
        for (int i = 0; i < 5; i++) begin
            cur = '0; cur.dx_is_multdiv = 1;
            settle(); advance();
        end
        cur = '0; cur.dx_is_multdiv = 1; cur.dx_is_branch = 1; cur.dx_pc = 32'h84; cur.dx_taken = 1; cur.dx_pred_taken = 1;
        rst_n = 1'b0;
        settle(); advance();
        cur = '0;
        settle();
        chk("rst_mid_stall", stall, 1'b0);
        chk("rst_mid_busy", md_busy, 1'b0);
        advance();
        rst_n = 1'b1;
        nst = 0;
        for (int i = 0; i < 40; i++) begin
            cur = '0; cur.f_pc = 32'(i % BP_ENTRIES) << 2;
            settle();
            if (i < BP_ENTRIES) chk("rst_pred_weak_nt", pred_taken, 1'b0);
            if (stall) nst++;
            advance();
        end
        chki("rst_no_stall", nst, 0);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 80) != 0);
            cur.f_pc          = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            cur.dx_pc         = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            cur.fd_rs         = 5'($urandom_range(0, 3));
            cur.fd_rt         = 5'($urandom_range(0, 3));
            cur.dx_rd         = 5'($urandom_range(0, 3));
            cur.fd_uses_rs    = 1'($urandom_range(0, 1));
            cur.fd_uses_rt    = 1'($urandom_range(0, 1));
            cur.fd_is_jump    = ($urandom_range(0, 5) == 0);
            cur.dx_is_load    = ($urandom_range(0, 3) == 0);
            cur.dx_is_multdiv = ($urandom_range(0, 25) == 0);
            cur.dx_is_branch  = ($urandom_range(0, 2) == 0);
            cur.dx_is_jr      = ($urandom_range(0, 12) == 0);
            cur.dx_taken      = 1'($urandom_range(0, 1));
            cur.dx_pred_taken = 1'($urandom_range(0, 1));
            settle(); advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
